mod0_0: RTL and testbench
=========================

Name: mod0_0

Overview:
- First radix-2 stage of the 512-point, 16-lane streaming FFT pipeline; it produces the add/sub streams consumed by the stage-01 block.
- Accepts frames of 512 complex samples as 32 consecutive beats of 16 lanes.
- Pairs sample n with sample n+256 using a 16-beat delay line, then emits butterfly sum and difference streams.
- Applies the trivial -j twiddle to the upper half of the difference stream and pulses alert_mod01 on the first output beat of every frame.

Parameters:
- IN_WIDTH, 9, input sample width, signed <3.6>.
- OUT_WIDTH, 10, output width, signed <4.6>; must equal IN_WIDTH+1.
- LANES, 16, samples per beat.
- HALF_BEATS, 16, beats per half frame (256/LANES).

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- din_valid  input  1  input beat valid; must stay high for 32 consecutive beats per frame
- din_R  input  [IN_WIDTH-1:0] x [0:15]  real part of input lanes, signed
- din_Q  input  [IN_WIDTH-1:0] x [0:15]  imaginary part of input lanes, signed
- dout_R_add00  output  [OUT_WIDTH-1:0] x [0:15]  butterfly sum, real
- dout_Q_add00  output  [OUT_WIDTH-1:0] x [0:15]  butterfly sum, imag
- dout_R_sub00  output  [OUT_WIDTH-1:0] x [0:15]  butterfly difference after twiddle, real
- dout_Q_sub00  output  [OUT_WIDTH-1:0] x [0:15]  butterfly difference after twiddle, imag
- alert_mod01  output  1  single-cycle pulse on the first output beat of a frame
- frame_err  output  1  single-cycle pulse when a frame is aborted

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset state: all dout_* = 0, alert_mod01 = 0, frame_err = 0, beat counter = 0, delay line cleared, FSM = IDLE. Reset mid-frame discards the frame entirely; no alert follows until a new full frame is received.
- Indexing: beat counter cnt is 5 bits. Sample index is n = 16*cnt + lane.
- FSM IDLE: cnt = 0. Move to FILL when din_valid = 1; that beat is stored as cnt 0.
- FSM FILL (cnt 0..15): each valid beat is written into a 16-deep x 16-lane delay line. Outputs are driven 0.
- FSM BFLY (cnt 16..31): each valid beat x_cur is combined lane-wise with the delay-line head x_del (the sample from 16 beats earlier).
  - add = x_del + x_cur
  - sub = x_del - x_cur
  - Operands are sign-extended to OUT_WIDTH. Results are full precision: add range [-512, 510], sub range [-511, 511]. No saturation or rounding is required.
- Twiddle: for cnt 24..31 (difference index m = 16*(cnt-16) + lane >= 128), the difference is multiplied by -j before registering: R' = sub_Q, Q' = -sub_R. Negation cannot overflow because |sub| <= 511. For cnt 16..23 the difference passes through unchanged.
- Latency: outputs are registered; the result of the beat accepted at cnt = c appears on the following clock edge. Outputs are 0 in every cycle not carrying a BFLY result.
- alert_mod01: high exactly in the cycle the cnt = 16 result is on the outputs. Frames are 32 cycles apart when streamed back-to-back.
- Wrap: after cnt = 31, cnt returns to 0.
  - If din_valid = 1 in the next cycle, FILL of the next frame begins with no bubble.
  - If din_valid = 0, FSM returns to IDLE.
  - FILL of frame k+1 overlaps nothing, because BFLY outputs of frame k end on the edge after cnt = 31.
- Gaps:
  - din_valid = 0 while in IDLE is legal.
  - din_valid = 0 while in FILL or BFLY aborts the frame: frame_err pulses the next cycle, cnt returns to 0, outputs are forced to 0 from that cycle, FSM goes to IDLE, and no further alert is issued for that frame.
- Simultaneous events: an abort and a wrap cannot coincide, because the abort condition is evaluated only for cnt 1..31 with din_valid = 0. Reset overrides everything.

Test Plan:
1. Reset: assert rstn = 0 at cnt 20 of a streaming frame -> all outputs 0 immediately (asynchronous); after release, no alert until a complete new 32-beat frame is received, then alert fires 17 cycles after that frame's first beat.
2. Impulse: frame with only lane 0 at cnt 0 = (64, 0) -> in the alert cycle, add lane 0 = (64, 0) and sub lane 0 = (64, 0); all other lanes and cycles are 0; alert_mod01 pulses exactly once.
3. Twiddle: only lane 0 at cnt 8 = (100, -30) -> 8 cycles after alert, add lane 0 = (100, -30) and sub lane 0 = (-30, -100); the same stimulus at cnt 7 gives sub lane 0 = (100, -30) on the cycle 7 after alert.
4. Extremes: cnt 0..15 all lanes (-256, 255) and cnt 16..31 all lanes (255, -256) -> outputs at cnt 16..23: add = (-1, -1), sub = (-511, 511); outputs at cnt 24..31: sub = (511, 511).
5. Back-to-back: 3 contiguous frames -> alert pulses 32 cycles apart; no zero beats between the BFLY windows of consecutive frames except the 16-cycle FILL gap.
6. Abort: din_valid drops at cnt 20 -> frame_err = 1 one cycle later, outputs 0 from that cycle on, no alert; the next full frame then processes normally with a correct impulse response.

Source files
------------

// File: rtl/mod0_0_if.sv
// Stream bundle for the first radix-2 FFT stage: 16-lane complex input
// beats in, butterfly sum/difference beats plus frame status out.
interface mod0_0_if #(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = 10,
    parameter int LANES     = 16
);
    logic                        din_valid;
    logic signed [IN_WIDTH-1:0]  din_R        [0:LANES-1];
    logic signed [IN_WIDTH-1:0]  din_Q        [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] dout_R_add00 [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] dout_Q_add00 [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] dout_R_sub00 [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] dout_Q_sub00 [0:LANES-1];
    logic                        alert_mod01;
    logic                        frame_err;

    // Butterfly stage view: consumes samples, produces results.
    modport slave (
        input  din_valid, din_R, din_Q,
        output dout_R_add00, dout_Q_add00, dout_R_sub00, dout_Q_sub00,
        output alert_mod01, frame_err
    );

    // Upstream/downstream view: supplies samples, observes results.
    modport master (
        output din_valid, din_R, din_Q,
        input  dout_R_add00, dout_Q_add00, dout_R_sub00, dout_Q_sub00,
        input  alert_mod01, frame_err
    );
endinterface

// File: rtl/mod0_0.sv
// First radix-2 stage of the 512-point, 16-lane streaming FFT.
// A frame is 32 beats of 16 lanes. The first 16 beats fill a delay line;
// each of the last 16 beats is combined with the beat 16 earlier to form
// sum and difference. The upper half of the difference stream (index
// >= 128) is rotated by -j. Outputs are registered and zero whenever no
// butterfly result is present.
module mod0_0 #(
    parameter int IN_WIDTH   = 9,
    parameter int OUT_WIDTH  = 10,
    parameter int LANES      = 16,
    parameter int HALF_BEATS = 16
) (
    input  logic     clk,
    input  logic     rstn,
    mod0_0_if.slave  bus
);

    localparam int AW = $clog2(HALF_BEATS);
    localparam int EXT = OUT_WIDTH - IN_WIDTH;

    // Beat-count landmarks within a frame (cnt is 5 bits).
    localparam logic [4:0] LAST_FILL  = 5'(HALF_BEATS - 1);
    localparam logic [4:0] FIRST_BFLY = 5'(HALF_BEATS);
    localparam logic [4:0] TWID_START = 5'(HALF_BEATS + HALF_BEATS / 2);
    localparam logic [4:0] LAST_BEAT  = 5'(2 * HALF_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BFLY = 2'd2
    } state_t;

    state_t     state_reg;
    logic [4:0] cnt_reg;
    logic       alert_reg;
    logic       frame_err_reg;

    // Delay line: one row per beat of the first half frame.
    logic signed [IN_WIDTH-1:0] dl_R_reg [0:HALF_BEATS-1][0:LANES-1];
    logic signed [IN_WIDTH-1:0] dl_Q_reg [0:HALF_BEATS-1][0:LANES-1];

    // Registered butterfly outputs.
    logic signed [OUT_WIDTH-1:0] add_r_reg [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] add_q_reg [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_r_reg [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_q_reg [0:LANES-1];

    // Combinational butterfly results for the current beat.
    logic signed [OUT_WIDTH-1:0] add_r_next [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] add_q_next [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_r_next [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_q_next [0:LANES-1];

    logic [AW-1:0] dl_idx;
    logic          dl_wr;
    logic          rot;

    // The same row index serves both the FILL write and the BFLY read,
    // since beat c of the second half pairs with beat c-16 of the first.
    assign dl_idx = cnt_reg[AW-1:0];
    assign dl_wr  = bus.din_valid && ((state_reg == IDLE) || (state_reg == FILL));
    assign rot    = (cnt_reg >= TWID_START);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [IN_WIDTH-1:0]  del_r;
            logic signed [IN_WIDTH-1:0]  del_q;
            logic signed [OUT_WIDTH-1:0] del_r_ext;
            logic signed [OUT_WIDTH-1:0] del_q_ext;
            logic signed [OUT_WIDTH-1:0] cur_r_ext;
            logic signed [OUT_WIDTH-1:0] cur_q_ext;
            logic signed [OUT_WIDTH-1:0] dif_r;
            logic signed [OUT_WIDTH-1:0] dif_q;

            assign del_r = dl_R_reg[dl_idx][gi];
            assign del_q = dl_Q_reg[dl_idx][gi];

            // Sign-extend so sum and difference are full precision.
            assign del_r_ext = {{EXT{del_r[IN_WIDTH-1]}}, del_r};
            assign del_q_ext = {{EXT{del_q[IN_WIDTH-1]}}, del_q};
            assign cur_r_ext = {{EXT{bus.din_R[gi][IN_WIDTH-1]}}, bus.din_R[gi]};
            assign cur_q_ext = {{EXT{bus.din_Q[gi][IN_WIDTH-1]}}, bus.din_Q[gi]};

            assign add_r_next[gi] = del_r_ext + cur_r_ext;
            assign add_q_next[gi] = del_q_ext + cur_q_ext;
            assign dif_r          = del_r_ext - cur_r_ext;
            assign dif_q          = del_q_ext - cur_q_ext;

            // Multiply by -j: (a + jb)(-j) = b - ja. |dif| <= 511 so the
            // negation always fits.
            assign sub_r_next[gi] = rot ? dif_q  : dif_r;
            assign sub_q_next[gi] = rot ? -dif_r : dif_q;

            assign bus.dout_R_add00[gi] = add_r_reg[gi];
            assign bus.dout_Q_add00[gi] = add_q_reg[gi];
            assign bus.dout_R_sub00[gi] = sub_r_reg[gi];
            assign bus.dout_Q_sub00[gi] = sub_q_reg[gi];
        end
    endgenerate

    assign bus.alert_mod01 = alert_reg;
    assign bus.frame_err   = frame_err_reg;

    // Delay line: store first-half beats; cleared on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < HALF_BEATS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    dl_R_reg[b][l] <= '0;
                    dl_Q_reg[b][l] <= '0;
                end
            end
        end else if (dl_wr) begin
            for (int l = 0; l < LANES; l++) begin
                dl_R_reg[dl_idx][l] <= bus.din_R[l];
                dl_Q_reg[dl_idx][l] <= bus.din_Q[l];
            end
        end
    end

    // Frame FSM with registered outputs: count beats, detect aborts,
    // register butterfly results during the second half frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            alert_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                add_r_reg[l] <= '0;
                add_q_reg[l] <= '0;
                sub_r_reg[l] <= '0;
                sub_q_reg[l] <= '0;
            end
        end else begin
            // Outputs and pulses default to zero; only a BFLY beat sets them.
            alert_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                add_r_reg[l] <= '0;
                add_q_reg[l] <= '0;
                sub_r_reg[l] <= '0;
                sub_q_reg[l] <= '0;
            end

            case (state_reg)
                IDLE: begin
                    // A valid beat here is beat 0 of a new frame.
                    if (bus.din_valid) begin
                        cnt_reg   <= 5'd1;
                        state_reg <= FILL;
                    end
                end

                FILL: begin
                    if (!bus.din_valid) begin
                        frame_err_reg <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                        if (cnt_reg == LAST_FILL) begin
                            state_reg <= BFLY;
                        end
                    end
                end

                BFLY: begin
                    if (!bus.din_valid) begin
                        frame_err_reg <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        for (int l = 0; l < LANES; l++) begin
                            add_r_reg[l] <= add_r_next[l];
                            add_q_reg[l] <= add_q_next[l];
                            sub_r_reg[l] <= sub_r_next[l];
                            sub_q_reg[l] <= sub_q_next[l];
                        end
                        alert_reg <= (cnt_reg == FIRST_BFLY);
                        // 5-bit counter wraps 31 -> 0; IDLE then accepts the
                        // next frame's beat 0 without a bubble.
                        cnt_reg   <= cnt_reg + 5'd1;
                        if (cnt_reg == LAST_BEAT) begin
                            state_reg <= IDLE;
                        end
                    end
                end

                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod0_0.sv
// Directed testbench for the first radix-2 FFT stage.
module tb_mod0_0;
    localparam int IW = 9;
    localparam int OW = 10;
    localparam int L  = 16;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    // Stimulus for one frame: 32 beats x 16 lanes.
    logic signed [IW-1:0] st_R [0:31][0:L-1];
    logic signed [IW-1:0] st_Q [0:31][0:L-1];

    always #5 clk = ~clk;

    mod0_0_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LANES(L)) bus ();

    mod0_0 #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LANES(L), .HALF_BEATS(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // Number of lanes at index >= from with any nonzero output.
    function automatic int nonzero_lanes(input int from);
        int n = 0;
        for (int l = from; l < L; l++) begin
            if (bus.dout_R_add00[l] != 0 || bus.dout_Q_add00[l] != 0 ||
                bus.dout_R_sub00[l] != 0 || bus.dout_Q_sub00[l] != 0) n++;
        end
        return n;
    endfunction

    function automatic logic [4*OW-1:0] lane0();
        return {bus.dout_R_add00[0], bus.dout_Q_add00[0],
                bus.dout_R_sub00[0], bus.dout_Q_sub00[0]};
    endfunction

    function automatic logic [4*OW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {OW'(a), OW'(b), OW'(c), OW'(d)};
    endfunction

    task automatic clear_stim();
        for (int b = 0; b < 32; b++) begin
            for (int l = 0; l < L; l++) begin
                st_R[b][l] = '0;
                st_Q[b][l] = '0;
            end
        end
    endtask

    // Present beat b (or an idle beat) and return #1 after the clock edge.
    task automatic drive_beat(input bit v, input int b);
        @(negedge clk);
        bus.din_valid = v;
        for (int l = 0; l < L; l++) begin
            bus.din_R[l] = v ? st_R[b][l] : '0;
            bus.din_Q[l] = v ? st_Q[b][l] : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.din_valid = 1'b0;
        for (int l = 0; l < L; l++) begin
            bus.din_R[l] = '0;
            bus.din_Q[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (nonzero_lanes(0) !== 0) begin
            failures++;
            $display("FAIL reset_outputs: nonzero lanes %0d, want 0", nonzero_lanes(0));
        end
        checks++;
        if (bus.alert_mod01 !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: alert=%b err=%b, want 0 0", bus.alert_mod01, bus.frame_err);
        end
        @(negedge clk) rstn = 1'b1;

        // Stream to cnt 20; beat 4 data makes the cnt 20 result nonzero.
        clear_stim();
        st_R[4][0] = IW'(10);
        st_Q[4][0] = IW'(20);
        for (int b = 0; b <= 20; b++) drive_beat(1'b1, b);
        checks++;
        if (lane0() !== pack4(10, 20, 10, 20)) begin
            failures++;
            $display("FAIL reset_prefrm: lane0 %h, want %h", lane0(), pack4(10, 20, 10, 20));
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (nonzero_lanes(0) !== 0 || bus.alert_mod01 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: nonzero lanes %0d alert %b, want 0 0",
                     nonzero_lanes(0), bus.alert_mod01);
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b0, 0);
            checks++;
            if (bus.alert_mod01 !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_alert: got %b, want 0", bus.alert_mod01);
            end
        end
        clear_stim();
        st_R[0][0] = IW'(64);
        for (int b = 0; b < 32; b++) begin
            drive_beat(1'b1, b);
            checks++;
            if (bus.alert_mod01 !== (b == 16)) begin
                failures++;
                $display("FAIL reset_newframe_alert beat %0d: got %b, want %b", b, bus.alert_mod01, (b == 16));
            end
        end
        drive_beat(1'b0, 0);
    endtask

    task automatic test_impulse();
        logic [4*OW-1:0] exp;
        clear_stim();
        st_R[0][0] = IW'(64);
        for (int b = 0; b < 32; b++) begin
            drive_beat(1'b1, b);
            exp = (b == 16) ? pack4(64, 0, 64, 0) : pack4(0, 0, 0, 0);
            checks++;
            if (lane0() !== exp) begin
                failures++;
                $display("FAIL impulse_lane0 beat %0d: got %h, want %h", b, lane0(), exp);
            end
            checks++;
            if (nonzero_lanes(1) !== 0) begin
                failures++;
                $display("FAIL impulse_others beat %0d: nonzero lanes %0d, want 0", b, nonzero_lanes(1));
            end
            checks++;
            if (bus.alert_mod01 !== (b == 16)) begin
                failures++;
                $display("FAIL impulse_alert beat %0d: got %b, want %b", b, bus.alert_mod01, (b == 16));
            end
        end
        drive_beat(1'b0, 0);
        checks++;
        if (nonzero_lanes(0) !== 0 || bus.alert_mod01 !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL impulse_after: lanes %0d alert %b err %b, want 0 0 0",
                     nonzero_lanes(0), bus.alert_mod01, bus.frame_err);
        end
    endtask

    task automatic test_twiddle();
        logic [4*OW-1:0] exp;
        clear_stim();
        st_R[7][0] = IW'(100);
        st_Q[7][0] = IW'(-30);
        st_R[8][0] = IW'(100);
        st_Q[8][0] = IW'(-30);
        for (int b = 0; b < 32; b++) begin
            drive_beat(1'b1, b);
            if (b >= 16) begin
                if (b == 23)      exp = pack4(100, -30, 100, -30);
                else if (b == 24) exp = pack4(100, -30, -30, -100);
                else              exp = pack4(0, 0, 0, 0);
                checks++;
                if (lane0() !== exp) begin
                    failures++;
                    $display("FAIL twiddle_lane0 beat %0d: got %h, want %h", b, lane0(), exp);
                end
            end
        end
        drive_beat(1'b0, 0);
    endtask

    task automatic test_extremes();
        logic [4*OW-1:0] exp;
        logic [4*OW-1:0] got;
        clear_stim();
        for (int b = 0; b < 32; b++) begin
            for (int l = 0; l < L; l++) begin
                st_R[b][l] = (b < 16) ? IW'(-256) : IW'(255);
                st_Q[b][l] = (b < 16) ? IW'(255)  : IW'(-256);
            end
        end
        for (int b = 0; b < 32; b++) begin
            drive_beat(1'b1, b);
            if (b == 15) begin
                checks++;
                if (nonzero_lanes(0) !== 0) begin
                    failures++;
                    $display("FAIL extremes_fill: nonzero lanes %0d, want 0", nonzero_lanes(0));
                end
            end
            if (b >= 16) begin
                exp = (b < 24) ? pack4(-1, -1, -511, 511) : pack4(-1, -1, 511, 511);
                for (int l = 0; l < L; l++) begin
                    got = {bus.dout_R_add00[l], bus.dout_Q_add00[l],
                           bus.dout_R_sub00[l], bus.dout_Q_sub00[l]};
                    checks++;
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL extremes beat %0d lane %0d: got %h, want %h", b, l, got, exp);
                    end
                end
            end
        end
        drive_beat(1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int vals [0:2];
        int v;
        int b;
        logic [4*OW-1:0] exp;
        vals[0] = 64;
        vals[1] = -64;
        vals[2] = 100;
        for (int g = 0; g < 96; g++) begin
            b = g % 32;
            v = vals[g / 32];
            if (b == 0) begin
                clear_stim();
                st_R[0][0] = IW'(v);
            end
            drive_beat(1'b1, b);
            checks++;
            if (bus.alert_mod01 !== (b == 16)) begin
                failures++;
                $display("FAIL b2b_alert cycle %0d: got %b, want %b", g, bus.alert_mod01, (b == 16));
            end
            exp = (b == 16) ? pack4(v, 0, v, 0) : pack4(0, 0, 0, 0);
            checks++;
            if (lane0() !== exp || nonzero_lanes(1) !== 0) begin
                failures++;
                $display("FAIL b2b_data cycle %0d: lane0 %h others %0d, want %h 0",
                         g, lane0(), nonzero_lanes(1), exp);
            end
        end
        drive_beat(1'b0, 0);
        checks++;
        if (bus.frame_err !== 1'b0 || bus.alert_mod01 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: err %b alert %b, want 0 0", bus.frame_err, bus.alert_mod01);
        end
    endtask

    task automatic test_abort();
        clear_stim();
        st_R[0][0] = IW'(64);
        st_R[4][0] = IW'(10);
        for (int b = 0; b < 20; b++) begin
            drive_beat(1'b1, b);
            if (b == 19) begin
                checks++;
                if (bus.frame_err !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_pre_err: got %b, want 0", bus.frame_err);
                end
            end
        end
        drive_beat(1'b0, 20);
        checks++;
        if (bus.frame_err !== 1'b1) begin
            failures++;
            $display("FAIL abort_err: got %b, want 1", bus.frame_err);
        end
        checks++;
        if (nonzero_lanes(0) !== 0) begin
            failures++;
            $display("FAIL abort_outputs: nonzero lanes %0d, want 0", nonzero_lanes(0));
        end
        for (int i = 0; i < 2; i++) begin
            drive_beat(1'b0, 0);
            checks++;
            if (bus.frame_err !== 1'b0 || bus.alert_mod01 !== 1'b0 || nonzero_lanes(0) !== 0) begin
                failures++;
                $display("FAIL abort_quiet: err %b alert %b lanes %0d, want 0 0 0",
                         bus.frame_err, bus.alert_mod01, nonzero_lanes(0));
            end
        end
        clear_stim();
        st_R[0][0] = IW'(32);
        for (int b = 0; b < 32; b++) begin
            drive_beat(1'b1, b);
            checks++;
            if (bus.alert_mod01 !== (b == 16)) begin
                failures++;
                $display("FAIL abort_next_alert beat %0d: got %b, want %b", b, bus.alert_mod01, (b == 16));
            end
            if (b == 16) begin
                checks++;
                if (lane0() !== pack4(32, 0, 32, 0)) begin
                    failures++;
                    $display("FAIL abort_next_data: got %h, want %h", lane0(), pack4(32, 0, 32, 0));
                end
            end
        end
        drive_beat(1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_twiddle();
        test_extremes();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
